xbaseband_cmd_responder: RTL

//  CPU-side responder for the xbaseband custom-instruction port. Accepts custom-0

---
 rtl/xbb_pkg.sv | 35 +++
 rtl/xbb_cmd_fifo.sv | 45 ++++
 rtl/xbaseband_cmd_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/xbb_pkg.sv
// Shared constants, command payload layout and FSM encodings for the xbaseband responder.
package xbb_pkg;

   localparam logic [6:0]  XBB_OPCODE   = 7'b0001011;
   localparam int unsigned OPC_LSB      = 0;
   localparam int unsigned OPC_W        = 7;
   localparam int unsigned FUNCT3_LSB   = 12;
   localparam int unsigned FUNCT3_W     = 3;
   localparam int unsigned CFG_ADDR_LSB = 25;
   localparam int unsigned CMD_W        = 64;

   typedef enum logic [2:0] {
      OP_CFG_WR = 3'd0,
      OP_JOB    = 3'd1,
      OP_SYNC   = 3'd2
   } xbb_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      JOB_REQ,
      SYNC_WAIT
   } xbb_state_e;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] rs1;
   } xbb_cmd_t;

   // True when the instruction carries the custom-0 major opcode.
   function automatic logic isCustom0(input logic [31:0] instr);
      return instr[OPC_LSB +: OPC_W] == XBB_OPCODE;
   endfunction

endpackage

// File: rtl/xbb_cmd_fifo.sv
// Small synchronous command FIFO; head entry is valid whenever empty is low.
module xbb_cmd_fifo #(
   parameter int unsigned AWIDTH = 2,
   parameter int unsigned DWIDTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DWIDTH-1:0] pushData,
   input  logic              pop,
   output logic [DWIDTH-1:0] headData,
   output logic              full,
   output logic              empty,
   output logic [AWIDTH:0]   count
);

   localparam int unsigned DEPTH = 1 << AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wrPtr;
   logic [AWIDTH-1:0] rdPtr;

   assign full     = (count == (AWIDTH+1)'(DEPTH));
   assign empty    = (count == '0);
   assign headData = mem[rdPtr];

   // Pointer and occupancy bookkeeping; simultaneous push and pop keep count steady.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AWIDTH'(1);
         if (pop)  rdPtr <= rdPtr + AWIDTH'(1);
         count <= count + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
      end
   end

   // Storage array, written only on push; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/xbaseband_cmd_responder.sv
// Buffers custom-0 commands from the core and turns them into config writes,
// baseband job launches or sync barriers, one command at a time from the FIFO head.
module xbaseband_cmd_responder
   import xbb_pkg::*;
#(
   parameter int unsigned FIFO_AWIDTH = 2,
   parameter int unsigned CFG_AWIDTH  = 4,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  xbaseband_cmd_valid,
   output logic                  xbaseband_cmd_ready,
   input  logic [31:0]           xbaseband_cmd_payload_instruction,
   input  logic [31:0]           xbaseband_cmd_payload_rs1,
   output logic                  cfg_wr_valid,
   output logic [CFG_AWIDTH-1:0] cfg_wr_addr,
   output logic [31:0]           cfg_wr_data,
   output logic                  job_valid,
   input  logic                  job_ready,
   output logic [LEN_WIDTH-1:0]  job_len,
   input  logic                  job_done,
   output logic                  busy,
   output logic [7:0]            illegal_count
);

   xbb_cmd_t             head;
   xbb_cmd_t             pushCmd;
   logic [CMD_W-1:0]     headRaw;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [FIFO_AWIDTH:0] fifoCount;
   logic [FIFO_AWIDTH:0] countNext;
   logic                 push;
   logic                 pop;
   xbb_state_e           state;
   logic                 outstanding;
   logic                 outNext;
   logic [2:0]           funct3;
   logic [LEN_WIDTH-1:0] headLen;
   logic                 opOk;
   logic                 isCfg;
   logic                 isJob;
   logic                 isSync;
   logic                 isIllegal;
   logic                 jobHs;
   logic                 headReady;
   logic                 unusedBits;

   // Acceptance depends only on the registered occupancy and reset.
   assign xbaseband_cmd_ready = !reset && !fifoFull;
   assign push                = xbaseband_cmd_valid && xbaseband_cmd_ready;
   assign pushCmd             = '{instruction: xbaseband_cmd_payload_instruction,
                                  rs1:         xbaseband_cmd_payload_rs1};

   xbb_cmd_fifo #(
      .AWIDTH (FIFO_AWIDTH),
      .DWIDTH (CMD_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushData (pushCmd),
      .pop      (pop),
      .headData (headRaw),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Head-of-queue decode.
   assign head       = xbb_cmd_t'(headRaw);
   assign funct3     = head.instruction[FUNCT3_LSB +: FUNCT3_W];
   assign headLen    = head.rs1[LEN_WIDTH-1:0];
   assign opOk       = isCustom0(head.instruction);
   assign isCfg      = opOk && (funct3 == 3'(OP_CFG_WR));
   assign isJob      = opOk && (funct3 == 3'(OP_JOB));
   assign isSync     = opOk && (funct3 == 3'(OP_SYNC));
   assign isIllegal  = !(isCfg || isJob || isSync);
   assign headReady  = (state == IDLE) && !fifoEmpty;
   assign unusedBits = ^{head.instruction, head.rs1};

   // Every non-IDLE state still holds its command in the FIFO, so the head leaves on exit.
   assign jobHs = (state == JOB_REQ) && job_ready;
   assign pop   = (state == CFG) || jobHs || ((state == SYNC_WAIT) && !outstanding) ||
                  (headReady && (isIllegal || (isJob && !outstanding && (headLen == '0))));

   // Set on handshake beats a coincident done pulse.
   assign outNext   = jobHs || (outstanding && !job_done);
   assign countNext = fifoCount + (FIFO_AWIDTH+1)'(push) - (FIFO_AWIDTH+1)'(pop);

   // Command sequencer with registered strobes; busy is precomputed from next-cycle occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         outstanding   <= 1'b0;
         busy          <= 1'b0;
         cfg_wr_valid  <= 1'b0;
         cfg_wr_addr   <= '0;
         cfg_wr_data   <= '0;
         job_valid     <= 1'b0;
         job_len       <= '0;
         illegal_count <= '0;
      end else begin
         cfg_wr_valid <= 1'b0;
         outstanding  <= outNext;
         busy         <= (countNext != '0) || outNext;
         if (headReady && isIllegal && (illegal_count != 8'hFF))
            illegal_count <= illegal_count + 8'd1;
         case (state)
            IDLE: begin
               if (!fifoEmpty) begin
                  if (isCfg) begin
                     cfg_wr_valid <= 1'b1;
                     cfg_wr_addr  <= head.instruction[CFG_ADDR_LSB +: CFG_AWIDTH];
                     cfg_wr_data  <= head.rs1;
                     state        <= CFG;
                  end else if (isJob && !outstanding && (headLen != '0)) begin
                     job_valid <= 1'b1;
                     job_len   <= headLen;
                     state     <= JOB_REQ;
                  end else if (isSync) begin
                     state <= SYNC_WAIT;
                  end
               end
            end
            CFG:       state <= IDLE;
            JOB_REQ: begin
               if (job_ready) begin
                  job_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            SYNC_WAIT: if (!outstanding) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule
